ram_read_checker: RTL and testbench

Self-checking monitor for the 32x8 block-RAM test path. It sits downstream of the RAM stimulus generator and the RAM and taps the same `wea`/`addra`/`dina` bus that drives the RAM. It also observes the RAM read port `douta`. Every written location is recorded in a shadow store. In the following read phase, each `douta` is compared with the shadow value, and the block reports done/pass plus an error count for LEDs or ChipScope.

---
 rtl/ram_test_pkg.sv | 26 ++
 rtl/ram_read_checker_if.sv | 14 +
 rtl/ram_chk_pipe.sv | 49 ++++
 rtl/ram_read_checker.sv | 190 +++++++++++++++++++
 tb/tb_ram_read_checker.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_test_pkg.sv
// Shared types and constants for the 32x8 block-RAM test path.
package ram_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } ram_state_e;

  localparam int         RAM_ADDR_W  = 5;
  localparam int         RAM_DATA_W  = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Error counter increment that sticks at ERR_CNT_MAX instead of wrapping.
  function automatic logic [7:0] err_sat_inc(input logic [7:0] cnt);
    logic [7:0] res;
    if (cnt == ERR_CNT_MAX) begin
      res = cnt;
    end else begin
      res = cnt + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_read_checker_if.sv
// Tap of the RAM stimulus bus plus the RAM read port, as seen by the checker.
interface ram_read_checker_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  // Stimulus generator and RAM side drive everything the checker observes.
  modport master (output wea, output addra, output dina, output douta);
  modport slave  (input wea, input addra, input dina, input douta);
endinterface

// File: rtl/ram_chk_pipe.sv
// Delay line aligning issued read expectations with the RAM read latency.
module ram_chk_pipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_exp
);

  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_exp  [DEPTH];

  // Shift register of {valid, addr, expected}; a flush only kills valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_exp[i]  <= '0;
      end
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0]  <= i_push && i_vld;
      r_addr[0] <= i_addr;
      r_exp[0]  <= i_exp;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
        r_exp[i]  <= r_exp[i-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_addr = r_addr[DEPTH-1];
  assign o_exp  = r_exp[DEPTH-1];

endmodule

// File: rtl/ram_read_checker.sv
// Shadow-store checker for the block-RAM test path: records writes, compares reads.
// Define RAM_CHK_FIRST_ERR_EN to add the first-mismatch capture ports.
module ram_read_checker
  import ram_test_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_read_checker_if.slave bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [7:0]        o_err_cnt
`ifdef RAM_CHK_FIRST_ERR_EN
  ,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic [DATA_W-1:0] o_first_err_exp,
  output logic [DATA_W-1:0] o_first_err_got
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  ram_state_e        r_state;
  ram_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_shadow [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_checked;
  logic [7:0]        r_err_cnt;
  logic [7:0]        w_err_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic              w_new_pass;
  logic              w_issue;
  logic              w_flush;
  logic              w_cmp;
  logic              w_mis;
  logic              w_pipe_vld;
  logic [ADDR_W-1:0] w_pipe_addr;
  logic [DATA_W-1:0] w_pipe_exp;

  ram_chk_pipe #(
    .DEPTH  (READ_LAT),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_issue),
    .i_vld   (r_valid[bus.addra]),
    .i_addr  (bus.addra),
    .i_exp   (r_shadow[bus.addra]),
    .o_vld   (w_pipe_vld),
    .o_addr  (w_pipe_addr),
    .o_exp   (w_pipe_exp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the read phase ends once every written address was checked.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.wea) w_state_nxt = WRITE;
        else         w_state_nxt = IDLE;
      end
      WRITE: begin
        if (!bus.wea) w_state_nxt = READ;
        else          w_state_nxt = WRITE;
      end
      READ: begin
        if (bus.wea)                                   w_state_nxt = WRITE;
        else if ((r_checked == r_valid) && (|r_valid)) w_state_nxt = DONE;
        else                                           w_state_nxt = READ;
      end
      DONE: begin
        if (bus.wea) w_state_nxt = WRITE;
        else         w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Issue/compare controls; a new write burst clears ahead of any compare.
  always_comb begin
    w_new_pass = bus.wea && ((r_state == READ) || (r_state == DONE));
    w_issue    = (r_state == READ) && !bus.wea;
    w_flush    = (r_state == READ) && (w_state_nxt != READ);
    w_cmp      = w_pipe_vld && w_issue;
    w_mis      = w_cmp && (bus.douta != w_pipe_exp);
    if (w_new_pass) begin
      w_err_nxt = 8'd0;
    end else if (w_mis) begin
      w_err_nxt = err_sat_inc(r_err_cnt);
    end else begin
      w_err_nxt = r_err_cnt;
    end
  end

  // Shadow data has no reset: it is only consulted where valid is set.
  always_ff @(posedge clk) begin
    if (bus.wea) begin
      r_shadow[bus.addra] <= bus.dina;
    end
  end

  // Written-address map, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (bus.wea) begin
      r_valid[bus.addra] <= 1'b1;
    end
  end

  // Checked-address map and error counter, restarted on each new pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checked <= '0;
      r_err_cnt <= 8'd0;
    end else begin
      r_err_cnt <= w_err_nxt;
      if (w_new_pass) begin
        r_checked <= '0;
      end else if (w_cmp) begin
        r_checked[w_pipe_addr] <= 1'b1;
      end
    end
  end

  // Status flags registered from the next state so they align with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == WRITE) || (w_state_nxt == READ);
      r_done <= (w_state_nxt == DONE);
      r_pass <= (w_state_nxt == DONE) && (w_err_nxt == 8'd0);
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_err_cnt = r_err_cnt;

`ifdef RAM_CHK_FIRST_ERR_EN
  logic [ADDR_W-1:0] r_fe_addr;
  logic [DATA_W-1:0] r_fe_exp;
  logic [DATA_W-1:0] r_fe_got;

  // First mismatch of a pass is the one seen while the counter is still zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fe_addr <= '0;
      r_fe_exp  <= '0;
      r_fe_got  <= '0;
    end else if (w_new_pass) begin
      r_fe_addr <= '0;
      r_fe_exp  <= '0;
      r_fe_got  <= '0;
    end else if (w_mis && (r_err_cnt == 8'd0)) begin
      r_fe_addr <= w_pipe_addr;
      r_fe_exp  <= w_pipe_exp;
      r_fe_got  <= bus.douta;
    end
  end

  assign o_first_err_addr = r_fe_addr;
  assign o_first_err_exp  = r_fe_exp;
  assign o_first_err_got  = r_fe_got;
`endif

endmodule

// File: tb/tb_ram_read_checker.sv
// Scoreboard bench for ram_read_checker: expectations queued at stimulus, checked on done.
module tb_ram_read_checker;

  localparam int READ_LAT = 1;

  typedef struct {
    int err;
    int pass;
    int cyc;
    int fa;
    int fe;
    int fg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [7:0] o_err_cnt;
`ifdef RAM_CHK_FIRST_ERR_EN
  logic [4:0] o_fe_addr;
  logic [7:0] o_fe_exp;
  logic [7:0] o_fe_got;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  logic mon_prev = 1'b0;

  logic [7:0] mem [32];
  logic [7:0] rd1;
  logic [7:0] rd2;
  bit         corrupt = 1'b0;
  bit         force_zero = 1'b0;

  ram_read_checker_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  ram_read_checker #(.ADDR_W(5), .DATA_W(8), .READ_LAT(READ_LAT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pass           (o_pass),
    .o_err_cnt        (o_err_cnt)
`ifdef RAM_CHK_FIRST_ERR_EN
    ,
    .o_first_err_addr (o_fe_addr),
    .o_first_err_exp  (o_fe_exp),
    .o_first_err_got  (o_fe_got)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read-first, optional corruption of addr 5 or forced zero data.
  always @(posedge clk) begin
    if (bus.wea) mem[bus.addra] <= bus.dina;
    if (force_zero)                         rd1 <= 8'h00;
    else if (corrupt && bus.addra == 5'd5)  rd1 <= 8'hAA;
    else                                    rd1 <= mem[bus.addra];
    rd2 <= rd1;
  end
  assign bus.douta = (READ_LAT == 2) ? rd2 : rd1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drv(input bit w, input int a, input int d);
    bus.wea   = w;
    bus.addra = a[4:0];
    bus.dina  = d[7:0];
  endtask

  // Monitor: every rising done pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_done && !mon_prev) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("err_cnt", int'(o_err_cnt), e.err);
          chk("pass", int'(o_pass), e.pass);
`ifdef RAM_CHK_FIRST_ERR_EN
          chk("first_err_addr", int'(o_fe_addr), e.fa);
          chk("first_err_exp", int'(o_fe_exp), e.fe);
          chk("first_err_got", int'(o_fe_got), e.fg);
`endif
        end
      end
      mon_prev = o_done;
    end
  end

  task automatic write_burst(input bit chk_clear);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (chk_clear && i == 2) begin
        chk("newpass_busy", int'(o_busy), 1);
        chk("newpass_done", int'(o_done), 0);
        chk("newpass_err", int'(o_err_cnt), 0);
      end
      drv(1'b1, (i == 32) ? 0 : i, i);
    end
    @(negedge clk);
    drv(1'b0, 0, 0);
  endtask

  task automatic read_all(input int err, input int pass, input int fa, input int fe, input int fg);
    exp_t e;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drv(1'b0, a, 0);
      if (a == 31) begin
        e = '{err, pass, cyc + READ_LAT + 2, fa, fe, fg};
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 60; k++) begin
      if (o_done) break;
      @(negedge clk);
    end
    chk("done_seen", int'(o_done), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drv(1'b0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    drv(1'b0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_pass", int'(o_pass), 0);
    chk("rst_err", int'(o_err_cnt), 0);

    // Clean full pass.
    write_burst(1'b0);
    read_all(0, 1, 0, 0, 0);
    wait_done();

    // Corrupted addr 5, started from DONE.
    corrupt = 1'b1;
    write_burst(1'b0);
    read_all(1, 0, 5, 5, 8'hAA);
    wait_done();
    corrupt = 1'b0;

    // New burst from DONE with err_cnt=1 must clear it.
    write_burst(1'b1);
    read_all(0, 1, 0, 0, 0);
    wait_done();

    // Async reset in the middle of READ.
    corrupt = 1'b1;
    write_burst(1'b0);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      drv(1'b0, a, 0);
    end
    @(negedge clk);
    chk("midread_err", int'(o_err_cnt), 1);
    chk("midread_busy", int'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", int'(o_busy), 0);
    chk("async_done", int'(o_done), 0);
    chk("async_pass", int'(o_pass), 0);
    chk("async_err", int'(o_err_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    corrupt = 1'b0;
    write_burst(1'b0);
    read_all(0, 1, 0, 0, 0);
    wait_done();

    // Only addr 3 written: done follows its compare.
    do_reset();
    @(negedge clk);
    drv(1'b1, 3, 8'h3C);
    @(negedge clk);
    drv(1'b0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drv(1'b0, a, 0);
      if (a == 3) begin
        e = '{0, 1, cyc + READ_LAT + 2, 0, 0, 0};
        q.push_back(e);
      end
    end
    wait_done();

    // Saturation: 301 mismatching compares.
    @(negedge clk);
    drv(1'b1, 3, 8'h3C);
    @(negedge clk);
    drv(1'b1, 4, 8'h44);
    @(negedge clk);
    drv(1'b0, 0, 0);
    force_zero = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drv(1'b0, 3, 0);
    end
    @(negedge clk);
    drv(1'b0, 4, 0);
    e = '{255, 0, cyc + READ_LAT + 2, 3, 8'h3C, 0};
    q.push_back(e);
    wait_done();
    force_zero = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
